// File: rtl/ch_scan_31_pkg.sv
// Shared parameters and state encodings for the 31-channel scan readout.
// Sized to match the channel enable-register bank.
package ch_scan_31_pkg;

    localparam int NUM_CH   = 31;
    localparam int DATA_W   = 21;
    localparam int CH_IDX_W = 5;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    localparam logic [CH_IDX_W-1:0] LAST_IDX = CH_IDX_W'(NUM_CH - 1);

endpackage

// File: rtl/ch_scan_31_snap_bank.sv
// Snapshot register array with a global load strobe and a registered read mux.
// The read register is loaded with ch0 on the snapshot edge so the first beat has no bubble.
module ch_scan_31_snap_bank
    import ch_scan_31_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic                       adv,
    input  logic                       clr,
    input  logic [NUM_CH*DATA_W-1:0]   flat_in,
    input  logic [CH_IDX_W-1:0]        rd_idx,
    output logic [DATA_W-1:0]          rd_data
);

    logic [DATA_W-1:0] snap_q [NUM_CH];
    logic [DATA_W-1:0] snap_d [NUM_CH];
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_mux;

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            snap_d[k] = load ? flat_in[k*DATA_W +: DATA_W] : snap_q[k];
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (rd_idx == CH_IDX_W'(k)) begin
                rd_mux = snap_q[k];
            end
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (clr) begin
            rd_data_d = '0;
        end else if (load) begin
            rd_data_d = flat_in[DATA_W-1:0];
        end else if (adv) begin
            rd_data_d = rd_mux;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                snap_q[k] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                snap_q[k] <= snap_d[k];
            end
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ch_scan_31.sv
// Snapshots 31 channel values on start and streams them out over valid/ready.
// All outputs come straight from flops; next-state values are precomputed.
module ch_scan_31
    import ch_scan_31_pkg::*;
(
    input  logic                       clk,
    input  logic                       GlobalReset,
    input  logic                       start,
    input  logic [NUM_CH*DATA_W-1:0]   ch_x_flat,
    output logic [DATA_W-1:0]          out_data,
    output logic [CH_IDX_W-1:0]        out_ch,
    output logic                       out_valid,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       done
);

    logic [0:0]          state_q, state_d;
    logic [CH_IDX_W-1:0] idx_q, idx_d;
    logic                done_q, done_d;
    logic                last_q, last_d;
    logic                load;
    logic                adv;
    logic                clr;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        load    = 1'b0;
        adv     = 1'b0;
        clr     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SEND;
                    idx_d   = '0;
                    load    = 1'b1;
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                        clr     = 1'b1;
                    end else begin
                        idx_d = idx_q + CH_IDX_W'(1);
                        adv   = 1'b1;
                    end
                end
            end
        endcase
        last_d = (state_d == ST_SEND) && (idx_d == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            last_q  <= last_d;
        end
    end

    ch_scan_31_snap_bank u_bank (
        .clk     (clk),
        .rst     (GlobalReset),
        .load    (load),
        .adv     (adv),
        .clr     (clr),
        .flat_in (ch_x_flat),
        .rd_idx  (idx_d),
        .rd_data (out_data)
    );

    assign out_ch    = idx_q;
    assign out_valid = (state_q == ST_SEND);
    assign busy      = (state_q == ST_SEND);
    assign out_last  = last_q;
    assign done      = done_q;

endmodule

// File: tb/tb_ch_scan_31.sv
// Directed bench for ch_scan_31: streaming order, stalls, snapshot isolation,
// start filtering, mid-scan reset and extreme values.
module tb_ch_scan_31;
    import ch_scan_31_pkg::*;

    logic                     clk = 1'b0;
    logic                     GlobalReset;
    logic                     start;
    logic [NUM_CH*DATA_W-1:0] ch_x_flat;
    logic [DATA_W-1:0]        out_data;
    logic [CH_IDX_W-1:0]      out_ch;
    logic                     out_valid;
    logic                     out_last;
    logic                     out_ready;
    logic                     busy;
    logic                     done;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] exp_v [NUM_CH];

    always #5 clk = ~clk;

    ch_scan_31 dut (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .start       (start),
        .ch_x_flat   (ch_x_flat),
        .out_data    (out_data),
        .out_ch      (out_ch),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_flat();
        for (int k = 0; k < NUM_CH; k++) begin
            ch_x_flat[k*DATA_W +: DATA_W] = exp_v[k];
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_ch"}, out_ch, 0);
        chk({tag, "_last"}, out_last, 0);
    endtask

    // mode 0: ready high; 1: ready low on scan cycles 3-7; 2: ready toggles
    task automatic run_scan(input int mode, input bit inject);
        int n = 0;
        int cyc = 0;
        int dones = 0;
        bit fin = 0;
        bit stalled = 0;
        logic [DATA_W-1:0]   pd = '0;
        logic [CH_IDX_W-1:0] pc = '0;
        while (!fin && cyc < 400) begin
            if (done) begin
                dones++;
                fin = 1;
            end else if (n >= NUM_CH) begin
                chk("overrun", n, NUM_CH - 1);
                fin = 1;
            end else begin
                if (mode == 1) out_ready = !(cyc >= 2 && cyc <= 6);
                else if (mode == 2) out_ready = (cyc % 2 == 0);
                else out_ready = 1'b1;
                start = inject && (n == 5 || n == 20);
                if (stalled) begin
                    chk("hold_data", out_data, pd);
                    chk("hold_ch", out_ch, pc);
                end
                chk("beat_valid", out_valid, 1);
                chk("beat_busy", busy, 1);
                chk("beat_ch", out_ch, n);
                chk("beat_data", out_data, exp_v[n]);
                chk("beat_last", out_last, (n == NUM_CH - 1));
                stalled = !out_ready;
                pd = out_data;
                pc = out_ch;
                if (out_ready) n++;
                step();
                cyc++;
            end
        end
        start = 1'b0;
        chk("beats", n, NUM_CH);
        chk("done_seen", dones, 1);
        chk("end_valid", out_valid, 0);
        chk("end_busy", busy, 0);
        if (mode == 0) chk("scan_cycles", cyc, NUM_CH);
    endtask

    initial begin
        GlobalReset = 1'b1;
        start       = 1'b0;
        out_ready   = 1'b0;
        ch_x_flat   = '0;
        step();
        step();
        chk_idle("reset");
        chk("reset_data", out_data, 0);
        GlobalReset = 1'b0;

        // ready while idle must not start anything
        out_ready = 1'b1;
        step();
        step();
        chk_idle("idle_ready");

        // 1: plain scan
        for (int k = 0; k < NUM_CH; k++) exp_v[k] = DATA_W'(k * 1000 + 5);
        load_flat();
        do_start();
        run_scan(0, 0);
        step();
        chk("t1_done_once", done, 0);

        // 2: backpressure
        do_start();
        run_scan(1, 0);
        step();

        // 3: snapshot isolation
        for (int k = 0; k < NUM_CH; k++) exp_v[k] = DATA_W'(k * 7 + 1);
        load_flat();
        do_start();
        ch_x_flat = '1;
        run_scan(0, 0);
        step();

        // 4: start during scan ignored, start in done cycle accepted
        load_flat();
        do_start();
        run_scan(0, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t4_restart_valid", out_valid, 1);
        chk("t4_restart_ch", out_ch, 0);
        run_scan(0, 0);
        step();

        // 5: reset mid-scan
        do_start();
        out_ready = 1'b1;
        repeat (10) step();
        chk("t5_pre_ch", out_ch, 10);
        GlobalReset = 1'b1;
        step();
        GlobalReset = 1'b0;
        chk_idle("t5_rst");
        chk("t5_rst_data", out_data, 0);
        step();
        chk("t5_no_done", done, 0);
        start = 1'b1;
        GlobalReset = 1'b1;
        step();
        start = 1'b0;
        GlobalReset = 1'b0;
        chk_idle("t5_rst_prio");
        do_start();
        run_scan(0, 0);
        step();

        // 6: extreme values with toggling ready
        for (int k = 0; k < NUM_CH; k++) exp_v[k] = DATA_W'(k * 3);
        exp_v[0] = '0;
        exp_v[NUM_CH-1] = 21'h1FFFFF;
        load_flat();
        do_start();
        run_scan(2, 0);
        step();
        chk("t6_done_once", done, 0);
        step();
        chk("t6_done_twice", done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
